// File: rtl/mem_stage.sv
// Memory stage: serialises ALU results, performs one data-RAM access per
// memory op and holds a writeback token until the consumer acknowledges.
module mem_stage #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inValid,
  output logic        inReady,
  input  logic [31:0] dataIn1,
  input  logic [31:0] dataIn2,
  input  logic [31:0] srcDstIn,
  input  logic [31:0] cpsrIn,
  input  logic        wIn,
  input  logic        mIn,
  output logic        wbValid,
  input  logic        wbAck,
  output logic        wbEn,
  output logic [3:0]  wbReg,
  output logic [31:0] wbData,
  output logic [31:0] cpsrOut,
  output logic        addrFault,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WB
  } state_t;

  state_t      state_q, state_d;
  logic        ld_q, ld_d;
  logic [31:0] d2_q, d2_d;
  logic [31:0] sd_q, sd_d;
  logic [31:0] cpsr_q, cpsr_d;
  logic        en_q, en_d;
  logic [3:0]  reg_q, reg_d;
  logic [31:0] data_q, data_d;
  logic [31:0] cpsro_q, cpsro_d;
  logic [15:0] retired_q, retired_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] addr;
  logic [31:0] rd_data;
  logic [AW-1:0] widx;
  logic        fault;
  logic        we;

  // loads address via dataIn2, stores via srcDstIn
  assign addr    = ld_q ? d2_q : sd_q;
  assign fault   = (|addr[31:AW+2]) || (|addr[1:0]);
  assign widx    = addr[AW+1:2];
  assign rd_data = mem[widx];
  assign we      = (state_q == ACCESS) && !ld_q && !fault;

  always_comb begin
    state_d   = state_q;
    ld_d      = ld_q;
    d2_d      = d2_q;
    sd_d      = sd_q;
    cpsr_d    = cpsr_q;
    en_d      = en_q;
    reg_d     = reg_q;
    data_d    = data_q;
    cpsro_d   = cpsro_q;
    retired_d = retired_q;
    unique case (state_q)
      IDLE: begin
        if (inValid) begin
          ld_d   = dataIn1[0];
          d2_d   = dataIn2;
          sd_d   = srcDstIn;
          cpsr_d = cpsrIn;
          if (mIn) begin
            state_d = ACCESS;
          end else begin
            state_d = WB;
            en_d    = wIn;
            reg_d   = srcDstIn[3:0];
            data_d  = dataIn1;
            cpsro_d = cpsrIn;
          end
        end
      end
      ACCESS: begin
        state_d = WB;
        cpsro_d = cpsr_q;
        if (ld_q) begin
          en_d   = 1'b1;
          reg_d  = sd_q[3:0];
          data_d = fault ? 32'h0 : rd_data;
        end else begin
          en_d   = 1'b0;
          reg_d  = 4'h0;
          data_d = 32'h0;
        end
      end
      WB: begin
        if (wbAck) begin
          state_d   = IDLE;
          retired_d = retired_q + 16'h1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ld_q      <= 1'b0;
      d2_q      <= 32'h0;
      sd_q      <= 32'h0;
      cpsr_q    <= 32'h0;
      en_q      <= 1'b0;
      reg_q     <= 4'h0;
      data_q    <= 32'h0;
      cpsro_q   <= 32'h0;
      retired_q <= 16'h0;
    end else begin
      state_q   <= state_d;
      ld_q      <= ld_d;
      d2_q      <= d2_d;
      sd_q      <= sd_d;
      cpsr_q    <= cpsr_d;
      en_q      <= en_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      cpsro_q   <= cpsro_d;
      retired_q <= retired_d;
    end
  end

  // data RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= d2_q;
  end

  assign inReady   = (state_q == IDLE) && !reset;
  assign wbValid   = (state_q == WB);
  assign wbEn      = en_q && wbValid;
  assign wbReg     = reg_q;
  assign wbData    = data_q;
  assign cpsrOut   = cpsro_q;
  assign addrFault = (state_q == ACCESS) && fault;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random ops checked
// against a word-array model of the data RAM and token rules.
module tb_mem_stage;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [31:0] dataIn1;
  logic [31:0] dataIn2;
  logic [31:0] srcDstIn;
  logic [31:0] cpsrIn;
  logic        wIn;
  logic        mIn;
  logic        wbValid;
  logic        wbAck;
  logic        wbEn;
  logic [3:0]  wbReg;
  logic [31:0] wbData;
  logic [31:0] cpsrOut;
  logic        addrFault;
  logic [15:0] retired;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ram_m [DEPTH];
  logic [15:0] ret_m;

  mem_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .inValid  (inValid),
    .inReady  (inReady),
    .dataIn1  (dataIn1),
    .dataIn2  (dataIn2),
    .srcDstIn (srcDstIn),
    .cpsrIn   (cpsrIn),
    .wIn      (wIn),
    .mIn      (mIn),
    .wbValid  (wbValid),
    .wbAck    (wbAck),
    .wbEn     (wbEn),
    .wbReg    (wbReg),
    .wbData   (wbData),
    .cpsrOut  (cpsrOut),
    .addrFault(addrFault),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] sd,
                       input logic [31:0] cp, input logic w);
    inValid  = 1'b1;
    mIn      = m;
    dataIn1  = d1;
    dataIn2  = d2;
    srcDstIn = sd;
    cpsrIn   = cp;
    wIn      = w;
  endtask

  // one full transaction; expectations come from the model rules
  task automatic do_op(input logic m, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] sd,
                       input logic [31:0] cp, input logic w,
                       input int dly);
    logic        is_ld;
    logic [31:0] a;
    logic        flt;
    logic        en_e;
    logic [31:0] dat_e;
    is_ld = m && d1[0];
    a     = is_ld ? d2 : sd;
    flt   = m && ((a >= DEPTH * 4) || (a % 4 != 0));
    if (!m) begin
      en_e  = w;
      dat_e = d1;
    end else if (is_ld) begin
      en_e  = 1'b1;
      dat_e = flt ? 32'h0 : ram_m[int'(a / 4)];
    end else begin
      en_e  = 1'b0;
      dat_e = 32'h0;
      if (!flt) ram_m[int'(a / 4)] = d2;
    end
    @(negedge clk);
    chk("ready_before", inReady, 1);
    drive(m, d1, d2, sd, cp, w);
    @(negedge clk);
    inValid = 1'b0;
    if (m) begin
      chk("access_valid", wbValid, 0);
      chk("access_ready", inReady, 0);
      chk("access_fault", addrFault, flt);
      @(negedge clk);
      chk("fault_pulse_end", addrFault, 0);
    end
    for (int k = 0; k <= dly; k++) begin
      chk("wb_valid", wbValid, 1);
      chk("wb_en", wbEn, en_e);
      if (!(m && !is_ld)) chk("wb_reg", wbReg, sd[3:0]);
      chk("wb_data", wbData, dat_e);
      chk("wb_cpsr", cpsrOut, cp);
      chk("wb_ready", inReady, 0);
      if (k == dly) wbAck = 1'b1;
      @(negedge clk);
    end
    wbAck = 1'b0;
    ret_m = ret_m + 16'h1;
    chk("exit_valid", wbValid, 0);
    chk("exit_ready", inReady, 1);
    chk("retired", retired, ret_m);
    chk("cpsr_hold", cpsrOut, cp);
  endtask

  initial begin
    logic        m;
    logic        ld;
    logic [31:0] a;
    logic [31:0] d1;
    int          r;
    int          dly;

    reset   = 1'b1;
    inValid = 1'b0;
    wbAck   = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    inValid = 1'b0;
    ret_m   = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_wbValid", wbValid, 0);
    chk("rst_wbEn", wbEn, 0);
    chk("rst_wbReg", wbReg, 0);
    chk("rst_wbData", wbData, 0);
    chk("rst_cpsr", cpsrOut, 0);
    chk("rst_fault", addrFault, 0);
    chk("rst_retired", retired, 0);
    reset = 1'b0;
    #1 chk("rst_release_ready", inReady, 1);

    // ack pulsed with no token pending must not count
    @(negedge clk);
    wbAck = 1'b1;
    @(negedge clk);
    wbAck = 1'b0;
    chk("stray_ack", retired, 0);

    do_op(0, 32'h1234, 32'h0, 32'd5, 32'hA000_0001, 1, 0);

    for (int i = 0; i < DEPTH; i++)
      do_op(1, 32'h0, $urandom, i * 4, 32'h0, 0, 0);

    do_op(1, 32'h0, 32'hDEAD_BEEF, 32'h10, 32'h1, 0, 0);
    do_op(1, 32'h1, 32'h10, 32'd3, 32'h2, 0, 1);

    // backpressure with a second request waiting
    @(negedge clk);
    drive(0, 32'hAAAA, 0, 32'd7, 32'h7, 1);
    @(negedge clk);
    drive(0, 32'hBBBB, 0, 32'd9, 32'h9, 0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", wbValid, 1);
      chk("bp_data", wbData, 32'hAAAA);
      chk("bp_reg", wbReg, 7);
      chk("bp_ready", inReady, 0);
      @(negedge clk);
    end
    wbAck = 1'b1;
    @(negedge clk);
    wbAck = 1'b0;
    ret_m = ret_m + 16'h1;
    chk("bp_exit_valid", wbValid, 0);
    chk("bp_exit_ready", inReady, 1);
    chk("bp_retired", retired, ret_m);
    @(negedge clk);
    inValid = 1'b0;
    chk("bp2_valid", wbValid, 1);
    chk("bp2_data", wbData, 32'hBBBB);
    chk("bp2_en", wbEn, 0);
    chk("bp2_reg", wbReg, 9);
    wbAck = 1'b1;
    @(negedge clk);
    wbAck = 1'b0;
    ret_m = ret_m + 16'h1;
    chk("bp2_retired", retired, ret_m);

    do_op(1, 32'h1, 32'h102, 32'd4, 32'h3, 0, 0);
    do_op(1, 32'h0, 32'h1357_9BDF, 32'h400, 32'h4, 0, 0);
    do_op(1, 32'h1, 32'h0, 32'd6, 32'h5, 0, 0);

    // reset while a store sits in ACCESS
    @(negedge clk);
    drive(1, 32'h0, 32'h55AA_55AA, 32'h20, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    inValid = 1'b0;
    reset   = 1'b1;
    #1;
    chk("ar_wbValid", wbValid, 0);
    chk("ar_wbEn", wbEn, 0);
    chk("ar_wbReg", wbReg, 0);
    chk("ar_wbData", wbData, 0);
    chk("ar_cpsr", cpsrOut, 0);
    chk("ar_fault", addrFault, 0);
    chk("ar_retired", retired, 0);
    @(negedge clk);
    reset = 1'b0;
    ret_m = 16'h0;
    #1 chk("ar_ready", inReady, 1);
    do_op(1, 32'h1, 32'h20, 32'd8, 32'h6, 0, 0);

    for (int i = 0; i < 80; i++) begin
      m   = ($urandom_range(0, 2) != 0);
      ld  = $urandom_range(0, 1) == 1;
      r   = $urandom_range(0, 9);
      dly = $urandom_range(0, 3);
      a   = 32'($urandom_range(0, DEPTH - 1)) * 4;
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = a | (32'h1 << $urandom_range(AW + 2, 31));
      d1  = $urandom;
      if (!m)
        do_op(0, d1, $urandom, $urandom, $urandom,
              $urandom_range(0, 1) == 1, dly);
      else if (ld)
        do_op(1, d1 | 32'h1, a, $urandom, $urandom, 0, dly);
      else
        do_op(1, d1 & ~32'h1, $urandom, a, $urandom, 0, dly);
    end

    // jump the counter to its top value, then retire one more
    @(negedge clk);
    force dut.retired_q = 16'hFFFF;
    #1 release dut.retired_q;
    ret_m = 16'hFFFF;
    chk("wrap_pre", retired, 16'hFFFF);
    do_op(0, 32'h77, 32'h0, 32'd1, 32'h8, 1, 0);
    chk("wrap_zero", retired, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
